mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 158 +++++++++++++++
 tb/tb_mem_access_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: ALU pass-through or stalled data-memory access with timeout
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] alu_result,
  input  logic        rf_write,
  input  logic        memtoreg,
  input  logic [3:0]  rf_write_reg,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic [15:0] dm_data_out,
  output logic [15:0] result_out,
  output logic        rf_write_out,
  output logic        memtoreg_out,
  output logic [3:0]  rf_write_reg_out,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [15:0] l_addr;
  logic [15:0] l_wdata;
  logic [15:0] l_alu;
  logic        l_rf_write;
  logic        l_memtoreg;
  logic [3:0]  l_reg;
  logic        l_we;
  logic [15:0] data_r;
  logic [7:0]  wait_cnt;
  logic        timeout_flag;

  logic in_v;
  logic mem_op;

  // in_valid is gated by reset so outputs fall to idle values immediately
  assign in_v   = in_valid & rst;
  assign mem_op = mem_read | mem_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      l_addr       <= '0;
      l_wdata      <= '0;
      l_alu        <= '0;
      l_rf_write   <= 1'b0;
      l_memtoreg   <= 1'b0;
      l_reg        <= '0;
      l_we         <= 1'b0;
      data_r       <= '0;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && mem_op) begin
            l_addr       <= addr;
            l_wdata      <= wdata;
            l_alu        <= alu_result;
            l_rf_write   <= rf_write;
            l_memtoreg   <= memtoreg;
            l_reg        <= rf_write_reg;
            l_we         <= mem_write;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
            state        <= REQ;
          end
        end
        REQ: begin
          // an ack in the final wait cycle wins over the timeout
          if (mem_ack) begin
            data_r       <= l_we ? 16'h0000 : mem_rdata;
            timeout_flag <= 1'b0;
            state        <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            data_r       <= 16'h0000;
            timeout_flag <= 1'b1;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          timeout_flag <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall            = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    out_valid        = 1'b0;
    dm_data_out      = '0;
    result_out       = '0;
    rf_write_out     = 1'b0;
    memtoreg_out     = 1'b0;
    rf_write_reg_out = '0;
    err              = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (in_v) begin
            if (mem_op) begin
              stall = 1'b1;
            end else begin
              out_valid        = 1'b1;
              result_out       = alu_result;
              rf_write_out     = rf_write;
              memtoreg_out     = memtoreg;
              rf_write_reg_out = rf_write_reg;
            end
          end
        end
        REQ: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = l_we;
          mem_addr  = l_addr;
          mem_wdata = l_wdata;
        end
        DONE: begin
          out_valid        = 1'b1;
          dm_data_out      = data_r;
          result_out       = l_alu;
          rf_write_out     = l_rf_write;
          memtoreg_out     = l_memtoreg;
          rf_write_reg_out = l_reg;
          err              = timeout_flag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage (MAX_WAIT=4)
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] alu_result;
  logic        rf_write;
  logic        memtoreg;
  logic [3:0]  rf_write_reg;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [15:0] dm_data_out;
  logic [15:0] result_out;
  logic        rf_write_out;
  logic        memtoreg_out;
  logic [3:0]  rf_write_reg_out;
  logic        err;

  int checks = 0;
  int errors = 0;
  int req_n;
  int stall_n;

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .alu_result(alu_result),
    .rf_write(rf_write), .memtoreg(memtoreg), .rf_write_reg(rf_write_reg),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .dm_data_out(dm_data_out), .result_out(result_out),
    .rf_write_out(rf_write_out), .memtoreg_out(memtoreg_out),
    .rf_write_reg_out(rf_write_reg_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] alu, input logic rfw,
                        input logic m2r, input logic [3:0] rr);
    in_valid = v; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    alu_result = alu; rf_write = rfw; memtoreg = m2r; rf_write_reg = rr;
  endtask

  // Presents a memory op and holds it until out_valid; ack_at=0 means never acknowledge.
  task automatic mem_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] alu, input logic [3:0] rr, input int ack_at,
                        input logic [15:0] rdata, output int reqs, output int stalls);
    bit done = 0;
    reqs = 0;
    stalls = 0;
    @(negedge clk);
    set_in(1'b1, rd, wr, a, wd, alu, 1'b1, rd & ~wr, rr);
    for (int i = 0; i < 40 && !done; i++) begin
      mem_ack = 1'b0;
      #1;
      if (out_valid) begin
        done = 1;
      end else begin
        if (stall) stalls++;
        if (mem_req) begin
          reqs++;
          check("req_addr", mem_addr, a);
          check("req_we", mem_we, wr);
          check("req_wdata", mem_wdata, wd);
          if (reqs == ack_at) begin
            mem_ack = 1'b1;
            mem_rdata = rdata;
          end
        end
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    check("done_reached", done, 1);
    check("done_stall", stall, 0);
    check("done_mem_req", mem_req, 0);
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    #1;
    check({tag, "_err_next"}, err, 0);
    check({tag, "_valid_next"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    set_in(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b1, 4'h7);
    #1;
    check("rst_stall", stall, 0);
    check("rst_valid", out_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_rf_write", rf_write_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 4'h3);
    #1;
    check("idle_valid", out_valid, 0);
    check("idle_rf_write", rf_write_out, 0);
    check("idle_result", result_out, 0);

    // ALU pass-through
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234, 1'b1, 1'b0, 4'd5);
    #1;
    check("pt_valid", out_valid, 1);
    check("pt_result", result_out, 16'h1234);
    check("pt_reg", rf_write_reg_out, 5);
    check("pt_rf_write", rf_write_out, 1);
    check("pt_stall", stall, 0);
    check("pt_dm", dm_data_out, 0);

    // ack while idle is ignored
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("idle_ack_req", mem_req, 0);
    check("idle_ack_valid", out_valid, 0);

    // load, ack on 3rd REQ cycle
    mem_op(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0040, 4'd2, 3, 16'hBEEF, req_n, stall_n);
    check("ld_req_cycles", req_n, 3);
    check("ld_stall_cycles", stall_n, 4);
    check("ld_dm", dm_data_out, 16'hBEEF);
    check("ld_memtoreg", memtoreg_out, 1);
    check("ld_valid", out_valid, 1);
    check("ld_reg", rf_write_reg_out, 2);
    check("ld_err", err, 0);
    idle_after("ld");

    // store, ack on 1st REQ cycle
    mem_op(1'b0, 1'b1, 16'h0002, 16'h00AA, 16'h0002, 4'd0, 1, 16'hFFFF, req_n, stall_n);
    check("st_req_cycles", req_n, 1);
    check("st_latency", stall_n + 1, 3);
    check("st_dm", dm_data_out, 0);
    check("st_memtoreg", memtoreg_out, 0);
    idle_after("st");

    // read+write together behaves as a write
    mem_op(1'b1, 1'b1, 16'h0100, 16'h0055, 16'h0100, 4'd9, 2, 16'hFFFF, req_n, stall_n);
    check("rw_req_cycles", req_n, 2);
    check("rw_dm", dm_data_out, 0);
    idle_after("rw");

    // timeout, never acknowledged
    mem_op(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0777, 4'd4, 0, 16'h0000, req_n, stall_n);
    check("to_req_cycles", req_n, 4);
    check("to_err", err, 1);
    check("to_dm", dm_data_out, 0);
    check("to_result", result_out, 16'h0777);
    idle_after("to");

    // ack coincident with the timeout cycle
    mem_op(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0300, 4'd1, 4, 16'h5A5A, req_n, stall_n);
    check("co_req_cycles", req_n, 4);
    check("co_err", err, 0);
    check("co_dm", dm_data_out, 16'h5A5A);
    idle_after("co");

    // reset asserted in the 2nd REQ cycle
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0400, 1'b1, 1'b1, 4'd6);
    @(negedge clk);
    #1;
    check("rr_req1", mem_req, 1);
    @(negedge clk);
    #1;
    check("rr_req2", mem_req, 1);
    rst = 1'b0;
    #1;
    check("rr_mem_req", mem_req, 0);
    check("rr_stall", stall, 0);
    check("rr_valid", out_valid, 0);
    check("rr_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rr_post_valid", out_valid, 0);
      check("rr_post_req", mem_req, 0);
      @(negedge clk);
    end
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'hCAFE, 1'b1, 1'b0, 4'd8);
    #1;
    check("rr_pt_valid", out_valid, 1);
    check("rr_pt_result", result_out, 16'hCAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
